// File: rtl/upsample_2x2.sv
// upsample_2x2 - nearest-neighbour 2x2 upsampler for the CNN decoder path.
//
// Takes a pooled feature map in raster order (12x12 in mode 0, 4x4 in
// mode 1) and emits the 2x expanded map in raster order (24x24 / 8x8).
// Every input pixel is sent twice horizontally while the row is written
// into a line buffer. The row is then replayed once from that buffer.
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   state              mode select, 0 = 12x12 -> 24x24, 1 = 4x4 -> 8x8
//                      (sampled only at a frame boundary)
//   ivalid/iready/din  input pixel stream (valid/ready)
//   ovalid/oready/dout output pixel stream (valid/ready)
//   frame_done         one-cycle pulse after the last output beat of a frame
module upsample_2x2 #(
  parameter int DATA_W   = 8,
  parameter int MAX_IN_W = 12
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              state,
  input  logic              ivalid,
  output logic              iready,
  input  logic [DATA_W-1:0] din,
  output logic              ovalid,
  input  logic              oready,
  output logic [DATA_W-1:0] dout,
  output logic              frame_done
);

  localparam int CW = $clog2(MAX_IN_W);

  typedef enum logic {
    ROW_A,
    ROW_B
  } fsm_t;

  fsm_t              fsm;
  logic [CW-1:0]     col;
  logic [CW-1:0]     row;
  logic              dup;
  logic              hold_valid;
  logic              mode;
  logic [DATA_W-1:0] hold;
  logic [DATA_W-1:0] lb [MAX_IN_W];

  logic [CW-1:0]     last_idx;
  logic [CW-1:0]     wr_idx;
  logic              last_col;
  logic              in_xfer;
  logic              out_xfer;

  // Geometry is square, so one index limit serves both col and row.
  // A new pixel may only be taken while the second copy of the held pixel
  // leaves, and never on the last column: that pixel belongs to the next
  // row, which must wait until the replay pass has finished.
  always_comb begin
    last_idx = mode ? CW'(3) : CW'(MAX_IN_W - 1);
    last_col = (col == last_idx);
    iready   = (fsm == ROW_A) && (!hold_valid || (dup && oready && !last_col));
    ovalid   = (fsm == ROW_A) ? hold_valid : 1'b1;
    dout     = (fsm == ROW_A) ? hold : lb[col];
    in_xfer  = ivalid && iready;
    out_xfer = ovalid && oready;
    // With hold occupied, an accepted pixel is the next column's pixel.
    wr_idx   = hold_valid ? (col + CW'(1)) : col;
  end

  // The line buffer needs no reset; each entry is written before it is read.
  always_ff @(posedge clk) begin
    if (in_xfer) begin
      lb[wr_idx] <= din;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fsm        <= ROW_A;
      col        <= '0;
      row        <= '0;
      dup        <= 1'b0;
      hold       <= '0;
      hold_valid <= 1'b0;
      frame_done <= 1'b0;
      mode       <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      // Mode can only change while idle at the start of a frame.
      if (fsm == ROW_A && row == '0 && col == '0 && !hold_valid) begin
        mode <= state;
      end

      case (fsm)
        ROW_A: begin
          if (in_xfer) begin
            hold       <= din;
            hold_valid <= 1'b1;
          end
          if (out_xfer) begin
            if (!dup) begin
              dup <= 1'b1;
            end else begin
              dup <= 1'b0;
              if (last_col) begin
                col        <= '0;
                fsm        <= ROW_B;
                hold_valid <= 1'b0;
              end else begin
                col        <= col + CW'(1);
                hold_valid <= in_xfer;
              end
            end
          end
        end

        ROW_B: begin
          if (out_xfer) begin
            if (!dup) begin
              dup <= 1'b1;
            end else begin
              dup <= 1'b0;
              if (last_col) begin
                col <= '0;
                fsm <= ROW_A;
                if (row == last_idx) begin
                  row        <= '0;
                  frame_done <= 1'b1;
                end else begin
                  row <= row + CW'(1);
                end
              end else begin
                col <= col + CW'(1);
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_upsample_2x2.sv
// tb_upsample_2x2 - directed self-checking bench for upsample_2x2.
//
// Each frame is driven cycle by cycle from one initial block. Expected
// output beats come from the nearest-neighbour rule out(r,c) = in(r/2,c/2),
// and the hand-computed frame timings are passed in per frame.
module tb_upsample_2x2;

  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rstn = 1'b1;
  logic              state;
  logic              ivalid;
  logic              iready;
  logic [DATA_W-1:0] din;
  logic              ovalid;
  logic              oready;
  logic [DATA_W-1:0] dout;
  logic              frame_done;

  int vectors = 0;
  int miscompares = 0;

  upsample_2x2 #(.DATA_W(DATA_W), .MAX_IN_W(12)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .state      (state),
    .ivalid     (ivalid),
    .iready     (iready),
    .din        (din),
    .ovalid     (ovalid),
    .oready     (oready),
    .dout       (dout),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] expBeat(input int b, input int w, input int base);
    int r;
    int c;
    r = b / (2 * w);
    c = b % (2 * w);
    return 32'((base + (r / 2) * w + c / 2) & 8'hFF);
  endfunction

  // Runs one frame. flipAfter >= 0 toggles `state` after that many accepts;
  // stopBeats > 0 abandons the frame after that many output beats.
  // Negative expectations skip the corresponding timing check.
  task automatic applyStimulus(input logic modeSel, input int base, input bit gaps,
                               input int flipAfter, input int stopBeats,
                               input int expDone, input int expLast,
                               input int expBubbles);
    int w, total, nIn;
    int accepted, beats, cyc, doneCycle, lastCycle, bubbles, viol;
    bit prevStall;
    logic [DATA_W-1:0] prevDout;
    w = modeSel ? 4 : 12;
    total = 4 * w * w;
    nIn = w * w;
    accepted = 0; beats = 0; cyc = 0; doneCycle = -1; lastCycle = -1;
    bubbles = 0; viol = 0; prevStall = 0; prevDout = '0;
    state = modeSel;
    while (cyc < 3000) begin
      @(negedge clk);
      ivalid = (accepted < nIn) && (!gaps || $urandom_range(0, 2) != 0);
      din    = DATA_W'(base + accepted);
      oready = !gaps || (cyc % 4 == 0) || (cyc % 4 == 3);
      #1;
      if (frame_done) begin
        doneCycle = cyc;
        if (beats != total) viol++;
        break;
      end
      if (stopBeats > 0 && beats == stopBeats) break;
      if (prevStall && dout !== prevDout) viol++;
      if (ovalid && iready && ((beats / (2 * w)) % 2 == 1)) viol++;
      if (!ovalid && beats < total) bubbles++;
      if (ovalid && oready) begin
        if (beats < total) checkOutput("beat", 32'(dout), expBeat(beats, w, base));
        if (beats == total - 1) lastCycle = cyc;
        beats++;
      end
      if (ivalid && iready) begin
        accepted++;
        if (accepted == flipAfter) state = !modeSel;
      end
      prevStall = ovalid && !oready;
      prevDout  = dout;
      cyc++;
    end
    ivalid = 1'b0;
    oready = 1'b1;
    checkOutput("protocol_violations", 32'(viol), 32'd0);
    if (stopBeats == 0) begin
      checkOutput("beat_count", 32'(beats), 32'(total));
      checkOutput("done_seen", 32'(doneCycle >= 0), 32'd1);
      if (expDone >= 0) checkOutput("done_cycle", 32'(doneCycle), 32'(expDone));
      if (expLast >= 0) checkOutput("last_beat_cycle", 32'(lastCycle), 32'(expLast));
      if (expBubbles >= 0) checkOutput("bubbles", 32'(bubbles), 32'(expBubbles));
    end else begin
      checkOutput("beats_before_abort", 32'(beats), 32'(stopBeats));
    end
  endtask

  initial begin
    bit doneSeen;
    state  = 1'b0;
    ivalid = 1'b0;
    oready = 1'b1;
    din    = '0;

    // Reset state.
    #2 rstn = 1'b0;
    #1;
    checkOutput("reset_ovalid", 32'(ovalid), 32'd0);
    checkOutput("reset_dout", 32'(dout), 32'd0);
    checkOutput("reset_iready", 32'(iready), 32'd1);
    checkOutput("reset_frame_done", 32'(frame_done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;

    $display("[TB] mode 1, 1..16 full rate");
    applyStimulus(1'b1, 1, 1'b0, -1, 0, 68, 67, 4);

    $display("[TB] mode 0, 0..143 full rate");
    applyStimulus(1'b0, 0, 1'b0, -1, 0, 588, 587, 12);

    $display("[TB] mode 1 with backpressure and input gaps");
    applyStimulus(1'b1, 1, 1'b1, -1, 0, -1, -1, -1);

    $display("[TB] state flipped mid-frame");
    applyStimulus(1'b0, 0, 1'b0, 30, 0, 588, 587, 12);
    applyStimulus(1'b1, 0, 1'b0, -1, 0, 68, 67, 4);

    $display("[TB] reset mid-frame");
    applyStimulus(1'b1, 1, 1'b0, -1, 20, -1, -1, -1);
    rstn = 1'b0;
    #1;
    checkOutput("midreset_ovalid", 32'(ovalid), 32'd0);
    checkOutput("midreset_dout", 32'(dout), 32'd0);
    checkOutput("midreset_iready", 32'(iready), 32'd1);
    @(negedge clk);
    rstn = 1'b1;
    doneSeen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      if (frame_done) doneSeen = 1'b1;
    end
    checkOutput("midreset_no_done", 32'(doneSeen), 32'd0);
    applyStimulus(1'b1, 1, 1'b0, -1, 0, 68, 67, 4);

    $display("[TB] two back-to-back mode 1 frames");
    applyStimulus(1'b1, 1, 1'b0, -1, 0, 68, 67, 4);
    applyStimulus(1'b1, 101, 1'b0, -1, 0, 68, 67, 4);

    // No stray frame_done once the stream is idle.
    doneSeen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      if (frame_done) doneSeen = 1'b1;
    end
    checkOutput("idle_no_done", 32'(doneSeen), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
